// File: rtl/uvma_obi_slv_mem_rsp.sv
// ----------------------------------------------------------------------------
// uvma_obi_slv_mem_rsp
// Synthesizable OBI responder. It sits on a DUT's OBI master port in place of
// system memory. It accepts address-phase transfers, services each one against
// an internal word-addressed memory, and returns the responses in order through
// a response FIFO.
//
// Ports
//   clk, reset_n          bus clock (rising edge); asynchronous active-low reset
//   req/gnt               address-phase handshake; a transfer is taken on a
//                         posedge with req=1 and gnt=1
//   addr/we/be/wdata/aid  address-phase payload
//   rvalid/rready         response handshake; a response is popped on a posedge
//                         with rvalid=1 and rready=1
//   rdata/err/rid         response payload, taken from the FIFO head
//   reqpar, rreadypar,    odd-parity companions of req/rready/gnt/rvalid and a
//   gntpar, rvalidpar,    sticky parity error flag
//   parity_err            (these ports exist only when UVMA_OBI_SLV_PARITY_EN
//                         is defined)
//
// Optional feature macro: UVMA_OBI_SLV_PARITY_EN
// ----------------------------------------------------------------------------
module uvma_obi_slv_mem_rsp #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int ID_WIDTH        = 4,
  parameter int MEM_DEPTH       = 1024,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req,
  output logic                    gnt,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [ID_WIDTH-1:0]     aid,
`ifdef UVMA_OBI_SLV_PARITY_EN
  input  logic                    reqpar,
  input  logic                    rreadypar,
  output logic                    gntpar,
  output logic                    rvalidpar,
  output logic                    parity_err,
`endif
  output logic                    rvalid,
  input  logic                    rready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    err,
  output logic [ID_WIDTH-1:0]     rid
);

  localparam int BE_W       = DATA_WIDTH / 8;
  localparam int BYTE_SHIFT = $clog2(BE_W);
  localparam int MEM_AW     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int PTR_W      = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W      = $clog2(MAX_OUTSTANDING + 1);
  // One extra bit so that MEM_DEPTH itself always fits in the comparison.
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(MEM_DEPTH);

  // Storage
  logic [DATA_WIDTH-1:0] mem_r       [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_r [MAX_OUTSTANDING];
  logic                  fifo_err_r  [MAX_OUTSTANDING];
  logic [ID_WIDTH-1:0]   fifo_id_r   [MAX_OUTSTANDING];

  logic                  ready_r;
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]      count_r;

  logic                  gnt_s;
  logic                  rvalid_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  in_range_s;
  logic                  wr_en_s;
  logic [ADDR_WIDTH-1:0] word_idx_s;
  logic [MEM_AW-1:0]     mem_idx_s;
  logic [DATA_WIDTH-1:0] mem_rd_s;
  logic [DATA_WIDTH-1:0] push_data_s;
  logic [PTR_W-1:0]      wr_ptr_nxt_s;
  logic [PTR_W-1:0]      rd_ptr_nxt_s;
  logic [CNT_W-1:0]      count_nxt_s;

  // Handshake decode. gnt is driven only from flops and ignores req, so a
  // full FIFO holds gnt low through the pop cycle (there is no bypass).
  always_comb begin
    gnt_s    = ready_r && (count_r < CNT_W'(MAX_OUTSTANDING));
    rvalid_s = (count_r != {CNT_W{1'b0}});
    push_s   = req && gnt_s;
    pop_s    = rvalid_s && rready;
  end

  // Address decode and the data that gets pushed. Out-of-range transfers
  // must not alias onto low memory through index truncation.
  always_comb begin
    word_idx_s = addr >> BYTE_SHIFT;
    in_range_s = ({1'b0, word_idx_s} < DEPTH_L);
    mem_idx_s  = word_idx_s[MEM_AW-1:0];
    mem_rd_s   = mem_r[mem_idx_s];
    wr_en_s    = push_s && we && in_range_s;
    if (in_range_s && !we) begin
      push_data_s = mem_rd_s;
    end else begin
      push_data_s = {DATA_WIDTH{1'b0}};
    end
  end

  // FIFO pointer wrap and occupancy update
  always_comb begin
    if (wr_ptr_r == PTR_W'(MAX_OUTSTANDING - 1)) begin
      wr_ptr_nxt_s = {PTR_W{1'b0}};
    end else begin
      wr_ptr_nxt_s = wr_ptr_r + PTR_W'(1);
    end
    if (rd_ptr_r == PTR_W'(MAX_OUTSTANDING - 1)) begin
      rd_ptr_nxt_s = {PTR_W{1'b0}};
    end else begin
      rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1);
    end
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Ready flop, FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_r  <= 1'b0;
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      ready_r <= 1'b1;
      count_r <= count_nxt_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_nxt_s;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_nxt_s;
      end
    end
  end

  // FIFO entry storage. It needs no reset because outputs are masked when empty.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_data_r[wr_ptr_r] <= push_data_s;
      fifo_err_r[wr_ptr_r]  <= !in_range_s;
      fifo_id_r[wr_ptr_r]   <= aid;
    end
  end

  // Memory write port with per-byte lane enables. Contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be[b]) begin
          mem_r[mem_idx_s][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // Response outputs: the FIFO head, forced to zero while empty
  always_comb begin
    if (rvalid_s) begin
      rdata = fifo_data_r[rd_ptr_r];
      err   = fifo_err_r[rd_ptr_r];
      rid   = fifo_id_r[rd_ptr_r];
    end else begin
      rdata = {DATA_WIDTH{1'b0}};
      err   = 1'b0;
      rid   = {ID_WIDTH{1'b0}};
    end
  end

  assign gnt    = gnt_s;
  assign rvalid = rvalid_s;

`ifdef UVMA_OBI_SLV_PARITY_EN
  logic parity_err_r;

  // Odd-parity companion of a single-bit signal
  function automatic logic odd_par(input logic b);
    return ~b;
  endfunction

  // Sticky parity error. A companion that equals its signal is a violation.
  // Acceptance is not blocked by it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      parity_err_r <= 1'b0;
    end else if ((reqpar == req) || (rreadypar == rready)) begin
      parity_err_r <= 1'b1;
    end
  end

  assign gntpar     = odd_par(gnt_s);
  assign rvalidpar  = odd_par(rvalid_s);
  assign parity_err = parity_err_r;
`endif

endmodule

// File: tb/tb_uvma_obi_slv_mem_rsp.sv
// ----------------------------------------------------------------------------
// Directed self-checking bench for uvma_obi_slv_mem_rsp (default parameters).
// Inputs change on the falling edge, the DUT samples on the rising edge, and
// outputs are compared on the following falling edge.
// ----------------------------------------------------------------------------
module tb_uvma_obi_slv_mem_rsp;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [3:0]  aid;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic        err;
  logic [3:0]  rid;

  int checks = 0;
  int errors = 0;

`ifdef UVMA_OBI_SLV_PARITY_EN
  logic reqpar, rreadypar, gntpar, rvalidpar, parity_err;
  logic par_bad = 1'b0;
  assign reqpar    = par_bad ? req : ~req;
  assign rreadypar = ~rready;
`endif

  always #5 clk = ~clk;

  uvma_obi_slv_mem_rsp dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .gnt        (gnt),
    .addr       (addr),
    .we         (we),
    .be         (be),
    .wdata      (wdata),
    .aid        (aid),
`ifdef UVMA_OBI_SLV_PARITY_EN
    .reqpar     (reqpar),
    .rreadypar  (rreadypar),
    .gntpar     (gntpar),
    .rvalidpar  (rvalidpar),
    .parity_err (parity_err),
`endif
    .rvalid     (rvalid),
    .rready     (rready),
    .rdata      (rdata),
    .err        (err),
    .rid        (rid)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b, input logic [3:0] id);
    req = r; we = w; addr = a; wdata = d; be = b; aid = id;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; rready = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 4'h0);
    repeat (3) @(negedge clk);
    checks++;
    if ({gnt, rvalid, err, rid, rdata} !== {1'b0, 1'b0, 1'b0, 4'h0, 32'h0}) begin
      errors++;
      $display("FAIL reset_outputs got gnt=%b rvalid=%b err=%b rid=%h rdata=%h want all 0",
               gnt, rvalid, err, rid, rdata);
    end
    reset_n = 1'b1;
    #1;
    checks++;
    if (gnt !== 1'b0) begin
      errors++; $display("FAIL gnt_before_first_edge got %b want 0", gnt);
    end
    step();
    checks++;
    if ({gnt, rvalid} !== 2'b10) begin
      errors++; $display("FAIL gnt_after_release got gnt=%b rvalid=%b want 1 0", gnt, rvalid);
    end
  endtask

  task automatic test_write_read();
    rready = 1'b1;
    drive(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 4'd3);
    step();
    checks++;
    if ({rvalid, err, rid, rdata} !== {1'b1, 1'b0, 4'd3, 32'h0}) begin
      errors++; $display("FAIL write_rsp got v=%b e=%b id=%h d=%h want 1 0 3 0", rvalid, err, rid, rdata);
    end
    drive(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 4'd5);
    step();
    checks++;
    if ({rvalid, err, rid, rdata} !== {1'b1, 1'b0, 4'd5, 32'hDEADBEEF}) begin
      errors++; $display("FAIL read_rsp got v=%b e=%b id=%h d=%h want 1 0 5 deadbeef", rvalid, err, rid, rdata);
    end
    req = 1'b0;
    step();
    checks++;
    if (rvalid !== 1'b0) begin
      errors++; $display("FAIL drain_after_read got rvalid=%b want 0", rvalid);
    end
  endtask

  task automatic test_byte_enable();
    rready = 1'b1;
    drive(1'b1, 1'b1, 32'h10, 32'h11223344, 4'h5, 4'd1);
    step();
    drive(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 4'd2);
    step();
    checks++;
    if ({err, rid, rdata} !== {1'b0, 4'd2, 32'hDE22BE44}) begin
      errors++; $display("FAIL byte_enable got e=%b id=%h d=%h want 0 2 de22be44", err, rid, rdata);
    end
    drive(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 4'd4);
    step();
    checks++;
    if ({err, rid, rdata} !== {1'b0, 4'd4, 32'hDE22BE44}) begin
      errors++; $display("FAIL read_be_zero got e=%b id=%h d=%h want 0 4 de22be44", err, rid, rdata);
    end
    req = 1'b0;
    step();
  endtask

  task automatic test_full();
    rready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 4'(8 + i));
      checks++;
      if (gnt !== 1'b1) begin
        errors++; $display("FAIL fill_gnt_%0d got %b want 1", i, gnt);
      end
      step();
    end
    drive(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 4'd12);
    checks++;
    if ({gnt, rvalid, rid} !== {1'b0, 1'b1, 4'd8}) begin
      errors++; $display("FAIL full_no_gnt got gnt=%b v=%b id=%h want 0 1 8", gnt, rvalid, rid);
    end
    step();
    checks++;
    if ({gnt, rid, rdata} !== {1'b0, 4'd8, 32'hDE22BE44}) begin
      errors++; $display("FAIL full_head_stable got gnt=%b id=%h d=%h want 0 8 de22be44", gnt, rid, rdata);
    end
    rready = 1'b1;
    step();
    checks++;
    if ({gnt, rid} !== {1'b1, 4'd9}) begin
      errors++; $display("FAIL gnt_after_pop got gnt=%b id=%h want 1 9", gnt, rid);
    end
    step();
    req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({rvalid, rid} !== {1'b1, 4'(10 + i)}) begin
        errors++; $display("FAIL order_%0d got v=%b id=%h want 1 %h", i, rvalid, rid, 4'(10 + i));
      end
      step();
    end
    checks++;
    if (rvalid !== 1'b0) begin
      errors++; $display("FAIL full_drain got rvalid=%b want 0", rvalid);
    end
  endtask

  task automatic test_out_of_range();
    rready = 1'b1;
    drive(1'b1, 1'b1, 32'h0, 32'h0BADC0DE, 4'hF, 4'd1);
    step();
    drive(1'b1, 1'b1, 32'd4096, 32'hCAFEF00D, 4'hF, 4'd6);
    step();
    checks++;
    if ({err, rid, rdata} !== {1'b1, 4'd6, 32'h0}) begin
      errors++; $display("FAIL oor_write got e=%b id=%h d=%h want 1 6 0", err, rid, rdata);
    end
    drive(1'b1, 1'b0, 32'd4096, 32'h0, 4'hF, 4'd7);
    step();
    checks++;
    if ({rvalid, err, rid, rdata} !== {1'b1, 1'b1, 4'd7, 32'h0}) begin
      errors++; $display("FAIL oor_read got v=%b e=%b id=%h d=%h want 1 1 7 0", rvalid, err, rid, rdata);
    end
    drive(1'b1, 1'b0, 32'h0, 32'h0, 4'hF, 4'd4);
    step();
    checks++;
    if ({err, rid, rdata} !== {1'b0, 4'd4, 32'h0BADC0DE}) begin
      errors++; $display("FAIL oor_no_alias got e=%b id=%h d=%h want 0 4 0badc0de", err, rid, rdata);
    end
    req = 1'b0;
    step();
  endtask

  task automatic test_reset_midflight();
    rready = 1'b0;
    drive(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 4'd2);
    step();
    step();
    req = 1'b0;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({gnt, rvalid, rid, rdata} !== {1'b0, 1'b0, 4'h0, 32'h0}) begin
      errors++; $display("FAIL midflight_reset got gnt=%b v=%b id=%h d=%h want 0 0 0 0", gnt, rvalid, rid, rdata);
    end
    @(negedge clk);
    reset_n = 1'b1;
    step();
    checks++;
    if ({gnt, rvalid} !== 2'b10) begin
      errors++; $display("FAIL midflight_recover got gnt=%b v=%b want 1 0", gnt, rvalid);
    end
  endtask

`ifdef UVMA_OBI_SLV_PARITY_EN
  task automatic test_parity();
    checks++;
    if ({parity_err, gntpar, rvalidpar} !== {1'b0, ~gnt, ~rvalid}) begin
      errors++; $display("FAIL parity_idle got pe=%b gp=%b vp=%b", parity_err, gntpar, rvalidpar);
    end
    par_bad = 1'b1;
    req = 1'b1; we = 1'b0; addr = 32'h10; aid = 4'd1; rready = 1'b1;
    step();
    par_bad = 1'b0; req = 1'b0;
    step();
    checks++;
    if ({parity_err, gntpar} !== {1'b1, ~gnt}) begin
      errors++; $display("FAIL parity_sticky got pe=%b gp=%b want 1 %b", parity_err, gntpar, ~gnt);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (parity_err !== 1'b0) begin
      errors++; $display("FAIL parity_reset got %b want 0", parity_err);
    end
    @(negedge clk);
    reset_n = 1'b1;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_byte_enable();
    test_full();
    test_out_of_range();
    test_reset_midflight();
`ifdef UVMA_OBI_SLV_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
